ntt_ctrl: RTL and testbench
===========================

NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter N, default 256: transform length, power of two, 8..1024.
REQ-002 SHALL have parameter LOG_N, default 8: log2(N).
REQ-003 SHALL have parameter BF_LAT, default 3: butterfly datapath latency in cycles, 1..8.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  request a transform; sampled only in IDLE.
REQ-007 SHALL have port inv  in  1  0 = forward (Cooley-Tukey), 1 = inverse (Gentleman-Sande); latched with start.
REQ-008 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port inv_mode  out  1  latched inv, held stable from the first RUN cycle until the next accepted start.
REQ-011 SHALL have port rd_en  out  1  butterfly issue strobe.
REQ-012 SHALL have ports rd_addr_a, rd_addr_b  out  LOG_N  coefficient pair addresses.
REQ-013 SHALL have port tw_idx  out  LOG_N  twiddle (zeta) table index, valid with rd_en.
REQ-014 SHALL have port wr_en  out  1  write-back strobe.
REQ-015 SHALL have ports wr_addr_a, wr_addr_b  out  LOG_N  write-back addresses.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE; all outputs registered.
REQ-017 SHALL transition IDLE->RUN on start=1; RUN->DRAIN after N/2 issues; DRAIN->RUN (next stage) after BF_LAT cycles; after last stage DRAIN->DONE; DONE->IDLE unconditionally.
REQ-018 SHALL execute LOG_N stages, each issuing exactly N/2 butterflies on consecutive cycles (rd_en continuously high in RUN).
REQ-019 Forward, stage s (0..LOG_N-1): len = N>>(s+1); blocks start at 0, 2len, 4len, ...; within a block j = start..start+len-1 issues a = j, b = j+len.
REQ-020 Forward twiddle: block counter k starts at 1 for the transform, increments by 1 per block across stages; tw_idx = k (range 1..N-1).
REQ-021 Inverse, stage s: len = 1<<s, same pair ordering; k starts at N-1, decrements per block; tw_idx = k (range N-1 down to 1).
REQ-022 SHALL assert wr_en, wr_addr_a, wr_addr_b exactly BF_LAT cycles after the matching rd_en, rd_addr_a, rd_addr_b (delay line of BF_LAT entries).
REQ-023 The last write of a stage SHALL occur in the final DRAIN cycle; the next stage's first read SHALL occur the cycle after it (no read-after-write hazard).
REQ-024 Total latency: start sampled in cycle 0; done high in cycle 1 + LOG_N*(N/2 + BF_LAT); busy high in cycles 1..LOG_N*(N/2 + BF_LAT).
REQ-025 start while not in IDLE (including DONE) SHALL be ignored; inv SHALL be sampled only with an accepted start.
REQ-026 rd_addr_*, tw_idx, wr_addr_* SHALL hold their last value when their strobe is low; consumers qualify with strobes.
REQ-027 Address arithmetic SHALL never exceed N-1 (b = j+len < N by construction; counters sized LOG_N+1 where needed to detect wrap).

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge regardless of state, clearing counters and the write delay line.
REQ-029 Post-reset values: busy=0, done=0, rd_en=0, wr_en=0, inv_mode=0, all addresses and tw_idx = 0.
REQ-030 Reset mid-transform SHALL suppress all pending wr_en (no write-back after reset) and no done pulse SHALL be produced.
REQ-031 rst and start high in the same cycle: rst wins; start is not accepted.

Verification
REQ-032 N=8, BF_LAT=3, forward: start cycle 0 -> pairs/tw (0,4)1 (1,5)1 (2,6)1 (3,7)1 cycles 1-4; (0,2)2 (1,3)2 (4,6)3 (5,7)3 cycles 8-11; (0,1)4 (2,3)5 (4,5)6 (6,7)7 cycles 15-18; done cycle 22.
REQ-033 N=8, BF_LAT=3, inverse: -> (0,1)7 (2,3)6 (4,5)5 (6,7)4; then (0,2)3 (1,3)3 (4,6)2 (5,7)2; then (0,4)1 x4; same cycle timing as REQ-032.
REQ-034 Check every wr_en/wr_addr equals rd_en/rd_addr delayed exactly 3 cycles; wr_en cycles 4-7, 11-14, 18-21 for N=8.
REQ-035 start pulsed in cycles 5 and 22 of a running transform -> ignored, single done at cycle 22, inv_mode unchanged.
REQ-036 rst in cycle 9 -> from cycle 10 busy=0, rd_en=0, wr_en=0 thereafter, no done; new start in cycle 12 -> full transform, done at cycle 34.
REQ-037 Default N=256, BF_LAT=3: done exactly 1049 cycles after start sampled; 1024 rd_en and 1024 wr_en pulses; tw_idx covers 1..255 once per block.

Source files
------------

// File: rtl/ntt_ctrl.sv
// NTT butterfly sequencer: issues coefficient pair addresses and twiddle indices stage by stage,
// and replays the read addresses as write-back addresses after the butterfly latency.
module ntt_ctrl #(
    parameter int N      = 256,
    parameter int LOG_N  = 8,
    parameter int BF_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inv,
    output logic             busy,
    output logic             done,
    output logic             inv_mode,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-1:0] tw_idx,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    localparam int SW = $clog2(LOG_N + 1);
    localparam int DW = $clog2(BF_LAT + 1);
    localparam logic [LOG_N-1:0] LastIssue = LOG_N'(N / 2 - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [LOG_N-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [LOG_N-1:0] k_q, k_d;
    logic             inv_q, inv_d;

    logic             busy_d, done_d, rd_en_d;
    logic [LOG_N-1:0] rd_a_d, rd_b_d, tw_d;
    logic [LOG_N-1:0] cur_mask, nxt_len, nxt_mask;

    logic             dl_en [BF_LAT];
    logic [LOG_N-1:0] dl_a  [BF_LAT];
    logic [LOG_N-1:0] dl_b  [BF_LAT];

    // Butterfly span: shrinks per stage for forward, grows per stage for inverse.
    function automatic logic [LOG_N-1:0] len_of(input logic [SW-1:0] s, input logic iv);
        logic [LOG_N:0] l;
        if (iv) l = (LOG_N+1)'(1) << s;
        else    l = (LOG_N+1)'(N) >> s >> 1;
        return l[LOG_N-1:0];
    endfunction

    assign cur_mask = len_of(stage_q, inv_q) - 1'b1;
    assign inv_mode = inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            k_q     <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            k_q     <= k_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        k_d     = k_q;
        inv_d   = inv_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    stage_d = '0;
                    cnt_d   = '0;
                    k_d     = inv ? LOG_N'(N - 1) : LOG_N'(1);
                    inv_d   = inv;
                end
            end
            StRun: begin
                // Twiddle index advances once the last pair of a block has been issued.
                if ((cnt_q & cur_mask) == cur_mask) k_d = inv_q ? k_q - 1'b1 : k_q + 1'b1;
                if (cnt_q == LastIssue) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DW'(BF_LAT - 1)) begin
                    if (stage_q == SW'(LOG_N - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        stage_d = stage_q + 1'b1;
                        cnt_d   = '0;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign nxt_len  = len_of(stage_d, inv_d);
    assign nxt_mask = nxt_len - 1'b1;

    always_comb begin
        busy_d  = (state_d == StRun) || (state_d == StDrain);
        done_d  = (state_d == StDone);
        rd_en_d = (state_d == StRun);
        rd_a_d  = rd_addr_a;
        rd_b_d  = rd_addr_b;
        tw_d    = tw_idx;
        if (rd_en_d) begin
            rd_a_d = ((cnt_d & ~nxt_mask) << 1) | (cnt_d & nxt_mask);
            rd_b_d = rd_a_d + nxt_len;
            tw_d   = k_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                dl_en[i] <= 1'b0;
                dl_a[i]  <= '0;
                dl_b[i]  <= '0;
            end
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            rd_en     <= rd_en_d;
            rd_addr_a <= rd_a_d;
            rd_addr_b <= rd_b_d;
            tw_idx    <= tw_d;
            dl_en[0]  <= rd_en;
            dl_a[0]   <= rd_addr_a;
            dl_b[0]   <= rd_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                dl_en[i] <= dl_en[i-1];
                dl_a[i]  <= dl_a[i-1];
                dl_b[i]  <= dl_b[i-1];
            end
        end
    end

    assign wr_en     = dl_en[BF_LAT-1];
    assign wr_addr_a = dl_a[BF_LAT-1];
    assign wr_addr_b = dl_b[BF_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Randomized bench for ntt_ctrl: an N=8 instance checked cycle by cycle against a pair-list model,
// plus a default-size instance checked for total latency, pulse counts and issue order.
module tb_ntt_ctrl;

    localparam int N8   = 8;
    localparam int LN8  = 3;
    localparam int BL   = 3;
    localparam int HALF = N8 / 2;
    localparam int T    = HALF + BL;
    localparam int TOT  = LN8 * T;

    typedef struct {int a; int b; int tw;} pair_t;

    logic       clk = 1'b0;
    logic       rst, start, inv;
    logic       busy, done, inv_mode, rd_en, wr_en;
    logic [2:0] rd_a, rd_b, tw, wr_a, wr_b;

    logic       b_rst, b_start, b_inv;
    logic       b_busy, b_done, b_inv_mode, b_rd_en, b_wr_en;
    logic [7:0] b_rd_a, b_rd_b, b_tw, b_wr_a, b_wr_b;

    int    n_checks = 0;
    int    n_errors = 0;
    pair_t ref_q[$];
    int    m_ra, m_rb, m_tw, m_wa, m_wb, m_inv;

    always #5 clk = ~clk;

    ntt_ctrl #(.N(N8), .LOG_N(LN8), .BF_LAT(BL)) u_dut (
        .clk(clk), .rst(rst), .start(start), .inv(inv), .busy(busy), .done(done),
        .inv_mode(inv_mode), .rd_en(rd_en), .rd_addr_a(rd_a), .rd_addr_b(rd_b), .tw_idx(tw),
        .wr_en(wr_en), .wr_addr_a(wr_a), .wr_addr_b(wr_b)
    );

    ntt_ctrl u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .inv(b_inv), .busy(b_busy), .done(b_done),
        .inv_mode(b_inv_mode), .rd_en(b_rd_en), .rd_addr_a(b_rd_a), .rd_addr_b(b_rd_b),
        .tw_idx(b_tw), .wr_en(b_wr_en), .wr_addr_a(b_wr_a), .wr_addr_b(b_wr_b)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue order straight from the stage/block/twiddle rules.
    task automatic build_ref(input int n, input int ln, input bit iv);
        int k;
        int len;
        ref_q.delete();
        k = iv ? n - 1 : 1;
        for (int s = 0; s < ln; s++) begin
            len = iv ? (1 << s) : (n >> (s + 1));
            for (int st = 0; st < n; st += 2 * len) begin
                for (int j = st; j < st + len; j++) ref_q.push_back('{a: j, b: j + len, tw: k});
                k = iv ? k - 1 : k + 1;
            end
        end
    endtask

    function automatic int issue_idx(input int c);
        int n;
        if (c < 1 || c > TOT) return -1;
        n = c - 1;
        if ((n % T) >= HALF) return -1;
        return (n / T) * HALF + (n % T);
    endfunction

    task automatic check_cycle(input int c, input bit inv_v, input bit after_rst);
        int ri, wi;
        ri = -1;
        wi = -1;
        if (after_rst) begin
            m_ra = 0; m_rb = 0; m_tw = 0; m_wa = 0; m_wb = 0; m_inv = 0;
        end else begin
            ri = issue_idx(c);
            wi = issue_idx(c - BL);
            if (ri >= 0) begin m_ra = ref_q[ri].a; m_rb = ref_q[ri].b; m_tw = ref_q[ri].tw; end
            if (wi >= 0) begin m_wa = ref_q[wi].a; m_wb = ref_q[wi].b; end
            m_inv = inv_v;
        end
        check_val($sformatf("busy@%0d", c), busy, int'(!after_rst && c >= 1 && c <= TOT));
        check_val($sformatf("done@%0d", c), done, int'(!after_rst && c == TOT + 1));
        check_val($sformatf("rd_en@%0d", c), rd_en, int'(ri >= 0));
        check_val($sformatf("rd_a@%0d", c), rd_a, m_ra);
        check_val($sformatf("rd_b@%0d", c), rd_b, m_rb);
        check_val($sformatf("tw@%0d", c), tw, m_tw);
        check_val($sformatf("wr_en@%0d", c), wr_en, int'(wi >= 0));
        check_val($sformatf("wr_a@%0d", c), wr_a, m_wa);
        check_val($sformatf("wr_b@%0d", c), wr_b, m_wb);
        check_val($sformatf("inv_mode@%0d", c), inv_mode, m_inv);
    endtask

    // One transform on the small instance; random ignored start/inv while busy, optional reset.
    task automatic run_xfer(input bit inv_v, input int rst_at);
        bit reset_done;
        reset_done = 1'b0;
        build_ref(N8, LN8, inv_v);
        for (int c = 0; c <= TOT + 2; c++) begin
            @(negedge clk);
            if (c > 0) check_cycle(c, inv_v, reset_done);
            rst = (c == rst_at);
            if (c == 0) begin
                start = 1'b1;
                inv   = inv_v;
            end else if (!reset_done && c <= TOT + 1) begin
                start = 1'($urandom_range(0, 1));
                inv   = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (c == rst_at) reset_done = 1'b1;
        end
    endtask

    task automatic run_big(input bit iv);
        int rdn, wrn, done_c, done_n, seq_err;
        rdn = 0; wrn = 0; done_c = -1; done_n = 0; seq_err = 0;
        build_ref(256, 8, iv);
        @(negedge clk);
        b_start = 1'b1;
        b_inv   = iv;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            b_inv   = 1'($urandom_range(0, 1));
            if (b_rd_en) begin
                if (rdn >= ref_q.size() || b_rd_a != 8'(ref_q[rdn].a) ||
                    b_rd_b != 8'(ref_q[rdn].b) || b_tw != 8'(ref_q[rdn].tw)) seq_err++;
                rdn++;
            end
            if (b_wr_en) wrn++;
            if (b_done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
        end
        check_val("big_done_cycle", done_c, 1049);
        check_val("big_done_count", done_n, 1);
        check_val("big_rd_count", rdn, 1024);
        check_val("big_wr_count", wrn, 1024);
        check_val("big_seq_errors", seq_err, 0);
        check_val("big_inv_mode", b_inv_mode, int'(iv));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; inv = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_inv = 1'b0;
        m_ra = 0; m_rb = 0; m_tw = 0; m_wa = 0; m_wb = 0; m_inv = 0;
        repeat (3) @(negedge clk);
        check_cycle(0, 1'b0, 1'b1);
        rst = 1'b0;
        b_rst = 1'b0;

        // Reset and start together: reset must win.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; inv = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; inv = 1'b0;
        check_val("rst_start_busy", busy, 0);
        check_val("rst_start_inv_mode", inv_mode, 0);
        @(negedge clk);
        check_val("rst_start_rd_en", rd_en, 0);

        run_xfer(1'b0, -1);
        run_xfer(1'b1, -1);
        run_xfer(1'b0, 9);
        run_xfer(1'b1, -1);
        for (int r = 0; r < 8; r++) begin
            run_xfer(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TOT + 1)) : -1);
        end

        run_big(1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
